// File: rtl/eh2_lsu_lr_reservation_if.sv
// LR/SC reservation bus: DC5 commit traffic, DMA snoop and flushes in,
// per-thread reservation status and SC verdict out.
interface eh2_lsu_lr_reservation_if #(
   parameter int NUM_THREADS = 2
);
   localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

   logic                   lr_commit_dc5;
   logic [TW-1:0]          lr_tid_dc5;
   logic [31:0]            lr_addr_dc5;
   logic                   sc_commit_dc5;
   logic [TW-1:0]          sc_tid_dc5;
   logic [31:0]            sc_addr_dc5;
   logic                   st_commit_dc5;
   logic [TW-1:0]          st_tid_dc5;
   logic [31:0]            st_addr_dc5;
   logic                   dma_wr_vld;
   logic [31:0]            dma_wr_addr;
   logic [NUM_THREADS-1:0] flush;
   logic [NUM_THREADS-1:0] lr_vld;
   logic                   sc_success_dc5;

   modport master (
      output lr_commit_dc5, lr_tid_dc5, lr_addr_dc5,
      output sc_commit_dc5, sc_tid_dc5, sc_addr_dc5,
      output st_commit_dc5, st_tid_dc5, st_addr_dc5,
      output dma_wr_vld, dma_wr_addr, flush,
      input  lr_vld, sc_success_dc5
   );

   modport slave (
      input  lr_commit_dc5, lr_tid_dc5, lr_addr_dc5,
      input  sc_commit_dc5, sc_tid_dc5, sc_addr_dc5,
      input  st_commit_dc5, st_tid_dc5, st_addr_dc5,
      input  dma_wr_vld, dma_wr_addr, flush,
      output lr_vld, sc_success_dc5
   );
endinterface

// File: rtl/eh2_lsu_lr_reservation.sv
// Per-thread load-reserved reservation tracker: records the LR word granule,
// judges SC success and drops reservations on snoop kills, flushes and timeout.
module eh2_lsu_lr_reservation #(
   parameter int NUM_THREADS = 2,
   parameter int LR_TIMEOUT  = 64
) (
   input  logic                       clk,
   input  logic                       rst_l,
   eh2_lsu_lr_reservation_if.slave    bus
);
   localparam int TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
   localparam logic [7:0] TMR_INIT = 8'(LR_TIMEOUT - 1);

   logic [NUM_THREADS-1:0] r_lr_vld;
   logic [29:0]            r_resv_addr [NUM_THREADS];
   logic [7:0]             r_tmr       [NUM_THREADS];

   logic [NUM_THREADS-1:0] w_kill;
   logic [NUM_THREADS-1:0] w_lr_hit;
   logic [NUM_THREADS-1:0] w_sc_hit;
   logic [NUM_THREADS-1:0] w_sc_match;
   logic                   w_sc_success;

   // A thread's own store never kills its reservation; other threads and DMA do.
   always_comb begin
      w_kill     = '0;
      w_lr_hit   = '0;
      w_sc_hit   = '0;
      w_sc_match = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         w_kill[t]     = (bus.st_commit_dc5 && (bus.st_tid_dc5 != TW'(t)) &&
                          (bus.st_addr_dc5[31:2] == r_resv_addr[t])) ||
                         (bus.dma_wr_vld && (bus.dma_wr_addr[31:2] == r_resv_addr[t]));
         w_lr_hit[t]   = bus.lr_commit_dc5 && (bus.lr_tid_dc5 == TW'(t));
         w_sc_hit[t]   = bus.sc_commit_dc5 && (bus.sc_tid_dc5 == TW'(t));
         w_sc_match[t] = bus.sc_addr_dc5[31:2] == r_resv_addr[t];
      end
   end

   assign w_sc_success = |(w_sc_hit & r_lr_vld & w_sc_match & ~w_kill & ~bus.flush);

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_lr_vld <= '0;
         for (int t = 0; t < NUM_THREADS; t++) begin
            r_resv_addr[t] <= '0;
            r_tmr[t]       <= '0;
         end
      end else begin
         for (int t = 0; t < NUM_THREADS; t++) begin
            if (bus.flush[t]) begin
               r_lr_vld[t] <= 1'b0;
            end else if (w_sc_hit[t]) begin
               r_lr_vld[t] <= 1'b0;
            end else if (w_lr_hit[t]) begin
               // A new LR wins over a same-cycle kill of the old granule.
               r_lr_vld[t]    <= 1'b1;
               r_resv_addr[t] <= bus.lr_addr_dc5[31:2];
               r_tmr[t]       <= TMR_INIT;
            end else if (w_kill[t]) begin
               r_lr_vld[t] <= 1'b0;
            end else if (r_lr_vld[t] && (r_tmr[t] == 8'd0)) begin
               r_lr_vld[t] <= 1'b0;
            end else if (r_lr_vld[t]) begin
               r_tmr[t] <= r_tmr[t] - 8'd1;
            end
         end
      end
   end

   assign bus.lr_vld         = r_lr_vld;
   assign bus.sc_success_dc5 = w_sc_success;

endmodule

// File: tb/tb_eh2_lsu_lr_reservation.sv
// Directed bench for eh2_lsu_lr_reservation: one-cycle vector table plus
// hand-written timeout, timer-restart and reset sequences.
module tb_eh2_lsu_lr_reservation;
   logic clk;
   logic rst_l;

   eh2_lsu_lr_reservation_if #(.NUM_THREADS(2)) bus ();

   eh2_lsu_lr_reservation #(
      .NUM_THREADS (2),
      .LR_TIMEOUT  (4)
   ) dut (
      .clk   (clk),
      .rst_l (rst_l),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        lr;
      logic        lr_tid;
      logic [31:0] lr_addr;
      logic        sc;
      logic        sc_tid;
      logic [31:0] sc_addr;
      logic        st;
      logic        st_tid;
      logic [31:0] st_addr;
      logic        dma;
      logic [31:0] dma_addr;
      logic [1:0]  flush;
      logic [1:0]  exp_vld;
      logic        exp_sc;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   always @(posedge clk) begin
      if (rst_l && bus.lr_commit_dc5 && bus.sc_commit_dc5 &&
          (bus.lr_tid_dc5 == bus.sc_tid_dc5))
         $error("illegal stimulus: LR and SC on the same thread in one cycle");
   end

   task automatic add(input logic lr, input logic lrt, input logic [31:0] lra,
                      input logic sc, input logic sct, input logic [31:0] sca,
                      input logic st, input logic stt, input logic [31:0] sta,
                      input logic dma, input logic [31:0] dmaa,
                      input logic [1:0] fl, input logic [1:0] ev, input logic es);
      vec_t v;
      v.lr = lr;   v.lr_tid = lrt; v.lr_addr = lra;
      v.sc = sc;   v.sc_tid = sct; v.sc_addr = sca;
      v.st = st;   v.st_tid = stt; v.st_addr = sta;
      v.dma = dma; v.dma_addr = dmaa;
      v.flush = fl; v.exp_vld = ev; v.exp_sc = es;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      bus.lr_commit_dc5 = v.lr;  bus.lr_tid_dc5 = v.lr_tid; bus.lr_addr_dc5 = v.lr_addr;
      bus.sc_commit_dc5 = v.sc;  bus.sc_tid_dc5 = v.sc_tid; bus.sc_addr_dc5 = v.sc_addr;
      bus.st_commit_dc5 = v.st;  bus.st_tid_dc5 = v.st_tid; bus.st_addr_dc5 = v.st_addr;
      bus.dma_wr_vld    = v.dma; bus.dma_wr_addr = v.dma_addr;
      bus.flush         = v.flush;
   endtask

   task automatic drive_idle();
      vec_t v;
      v = '{default: '0};
      drive(v);
   endtask

   task automatic drive_lr(input logic tid, input logic [31:0] addr);
      drive_idle();
      bus.lr_commit_dc5 = 1'b1; bus.lr_tid_dc5 = tid; bus.lr_addr_dc5 = addr;
   endtask

   task automatic drive_sc(input logic tid, input logic [31:0] addr);
      drive_idle();
      bus.sc_commit_dc5 = 1'b1; bus.sc_tid_dc5 = tid; bus.sc_addr_dc5 = addr;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   initial begin
      rst_l = 1'b0;
      drive_idle();

      //   lr t  lr_addr       sc t  sc_addr       st t  st_addr       dma dma_addr      flush  vld    sc
      // LR t0 then SC t0 three cycles later in the same word.
      add(1, 0, 32'h1000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      1, 0, 32'h1002,   0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 1);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      // Store from t1 kills t0; later SC fails.
      add(1, 0, 32'h2000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      1, 1, 32'h2003,   0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      1, 0, 32'h2000,   0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      // Own store keeps the reservation; SC passes.
      add(1, 0, 32'h2000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      1, 0, 32'h2003,   0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      1, 0, 32'h2000,   0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 1);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      // LR t0 + DMA same word + flush t1 in one cycle -> 2'b01.
      add(1, 1, 32'h3100,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(1, 0, 32'h4000,   0, 0, 32'h0,      0, 0, 32'h0,      1, 32'h4000,   2'b10, 2'b10, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      1, 0, 32'h4000,   0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 1);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      // SC with same-cycle DMA: other word leaves it intact, same word kills it.
      add(1, 0, 32'h5000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      1, 0, 32'h5000,   0, 0, 32'h0,      1, 32'h5004,   2'b00, 2'b01, 1);
      add(1, 0, 32'h5000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      1, 0, 32'h5000,   0, 0, 32'h0,      1, 32'h5000,   2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      // Back-to-back LR/SC on t1; other-word store survives; flush kills.
      add(1, 1, 32'h6000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      1, 1, 32'h6001,   0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b10, 1);
      add(1, 1, 32'h7000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      1, 0, 32'h7004,   0, 32'h0,      2'b00, 2'b10, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b10, 2'b10, 0);
      add(0, 0, 32'h0,      1, 1, 32'h7000,   0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      // Wrong-word SC fails and still clears the reservation.
      add(1, 0, 32'h8000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      1, 0, 32'h8004,   0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      // SC from t1 does not use or clear t0's reservation.
      add(1, 0, 32'h9000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      1, 1, 32'h9000,   0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 0);
      add(0, 0, 32'h0,      1, 0, 32'h9000,   0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b01, 1);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      // Flush in the SC cycle forces failure.
      add(1, 1, 32'hA000,   0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);
      add(0, 0, 32'h0,      1, 1, 32'hA000,   0, 0, 32'h0,      0, 32'h0,      2'b10, 2'b10, 0);
      add(0, 0, 32'h0,      0, 0, 32'h0,      0, 0, 32'h0,      0, 32'h0,      2'b00, 2'b00, 0);

      repeat (2) @(negedge clk);
      #2;
      check("reset_lr_vld", 32'(bus.lr_vld), 32'h0);
      check("reset_sc_success", 32'(bus.sc_success_dc5), 32'h0);
      @(negedge clk);
      rst_l = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #2;
         check($sformatf("vec%0d_lr_vld", i), 32'(bus.lr_vld), 32'(vecs[i].exp_vld));
         check($sformatf("vec%0d_sc_success", i), 32'(bus.sc_success_dc5), 32'(vecs[i].exp_sc));
         @(negedge clk);
      end

      // Timeout of 4: lr_vld[1] high on cycles 1..4, SC on cycle 5 fails.
      drive_lr(1'b1, 32'h3000);
      @(negedge clk);
      drive_idle();
      for (int i = 1; i <= 4; i++) begin
         #2;
         check($sformatf("tmo_hi_c%0d", i), 32'(bus.lr_vld[1]), 32'h1);
         @(negedge clk);
      end
      drive_sc(1'b1, 32'h3000);
      #2;
      check("tmo_lo_c5", 32'(bus.lr_vld[1]), 32'h0);
      check("tmo_sc_fail", 32'(bus.sc_success_dc5), 32'h0);
      @(negedge clk);
      drive_idle();
      @(negedge clk);

      // Second LR at cycle 2 restarts the timer: still live at 5 and 6, gone at 7.
      drive_lr(1'b0, 32'hB000);
      @(negedge clk);
      drive_idle();
      @(negedge clk);
      drive_lr(1'b0, 32'hB004);
      @(negedge clk);
      drive_idle();
      repeat (2) @(negedge clk);
      #2;
      check("restart_c5", 32'(bus.lr_vld[0]), 32'h1);
      @(negedge clk);
      drive_sc(1'b0, 32'hB004);
      #2;
      check("restart_c6_vld", 32'(bus.lr_vld[0]), 32'h1);
      check("restart_c6_sc", 32'(bus.sc_success_dc5), 32'h1);
      @(negedge clk);
      drive_idle();
      #2;
      check("restart_c7", 32'(bus.lr_vld[0]), 32'h0);
      @(negedge clk);

      // Reset mid-cycle with both threads reserved.
      drive_lr(1'b0, 32'hC000);
      @(negedge clk);
      drive_lr(1'b1, 32'hC100);
      @(negedge clk);
      drive_idle();
      #2;
      check("pre_reset_vld", 32'(bus.lr_vld), 32'h3);
      @(posedge clk);
      #3;
      rst_l = 1'b0;
      #1;
      check("async_reset_vld", 32'(bus.lr_vld), 32'h0);
      @(negedge clk);
      rst_l = 1'b1;
      drive_sc(1'b0, 32'hC000);
      #2;
      check("post_reset_sc", 32'(bus.sc_success_dc5), 32'h0);
      @(negedge clk);
      drive_idle();
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
